// File: rtl/iq_sample_unpack_if.sv
// Bundle between the serial-to-parallel merge stage, the I/Q unpack FIFO and
// the demodulator core: merged-word strobe in, valid/ready I/Q pairs out.
interface iq_sample_unpack_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int FILL_W = $clog2(DEPTH) + 1;

  logic [2*WIDTH-1:0]       word_i;
  logic                     word_valid_i;
  logic signed [WIDTH-1:0]  i_o;
  logic signed [WIDTH-1:0]  q_o;
  logic                     valid_o;
  logic                     ready_i;
  logic [FILL_W-1:0]        fill_o;
  logic                     overflow_o;
  logic [7:0]               drop_count_o;

  // Producer/consumer side: drives the word strobe and the consumer ready.
  modport master (
    output word_i, word_valid_i, ready_i,
    input  i_o, q_o, valid_o, fill_o, overflow_o, drop_count_o
  );

  // FIFO side.
  modport slave (
    input  word_i, word_valid_i, ready_i,
    output i_o, q_o, valid_o, fill_o, overflow_o, drop_count_o
  );
endinterface

// File: rtl/iq_sample_unpack.sv
// Captures merged 2*WIDTH-bit words, splits them into signed I/Q pairs and
// buffers them in a DEPTH-entry FIFO with sticky overflow and a drop counter.
module iq_sample_unpack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  iq_sample_unpack_if.slave bus
);
  localparam int AW     = $clog2(DEPTH);
  localparam int FILL_W = AW + 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [FILL_W-1:0]  fill;
  logic               overflow;
  logic [7:0]         drop_count;

  logic full;
  logic valid;
  logic pop;
  logic push;
  logic drop;

  assign full  = (fill == FILL_FULL);
  assign valid = (fill != '0);
  assign pop   = valid && bus.ready_i;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push  = bus.word_valid_i && (!full || pop);
  assign drop  = bus.word_valid_i && full && !pop;

  // NOTE: storage sits under the synchronous reset so the head reads 0 after
  // reset; sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.word_i;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   fill <= fill + FILL_W'(1);
        2'b01:   fill <= fill - FILL_W'(1);
        default: fill <= fill;
      endcase

      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end

  // Pure bit slice of the head entry: upper half is I, lower half is Q.
  assign bus.i_o          = mem[rd_ptr][2*WIDTH-1:WIDTH];
  assign bus.q_o          = mem[rd_ptr][WIDTH-1:0];
  assign bus.valid_o      = valid;
  assign bus.fill_o       = fill;
  assign bus.overflow_o   = overflow;
  assign bus.drop_count_o = drop_count;
endmodule

// File: tb/tb_iq_sample_unpack.sv
// Randomized and directed bench for iq_sample_unpack against a queue-based
// reference model of the I/Q pair FIFO.
module tb_iq_sample_unpack;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  iq_sample_unpack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  iq_sample_unpack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [2*WIDTH-1:0] mq[$];
  int                 m_drop = 0;
  bit                 m_ovf  = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, compare outputs against the model at the
  // falling edge, then advance the model by the FIFO rules.
  task automatic step(input bit wv, input logic [2*WIDTH-1:0] w, input bit rdy);
    bit m_full;
    bit m_pop;
    bus.word_valid_i = wv;
    bus.word_i       = wv ? w : 'x;
    bus.ready_i      = rdy;
    @(negedge clk);
    check("valid", 64'(bus.valid_o), 64'(mq.size() != 0));
    check("fill", 64'(bus.fill_o), 64'(mq.size()));
    check("overflow", 64'(bus.overflow_o), 64'(m_ovf));
    check("drop_count", 64'(bus.drop_count_o), 64'(m_drop));
    if (mq.size() != 0) begin
      check("i", {48'd0, bus.i_o}, {48'd0, mq[0][2*WIDTH-1:WIDTH]});
      check("q", {48'd0, bus.q_o}, {48'd0, mq[0][WIDTH-1:0]});
    end
    m_full = (mq.size() == DEPTH);
    m_pop  = rdy && (mq.size() != 0);
    if (m_pop) void'(mq.pop_front());
    if (wv && (!m_full || m_pop)) mq.push_back(w);
    else if (wv) begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end
    @(posedge clk);
    #1;
  endtask

  // One reset cycle, optionally with a strobe that must be ignored.
  task automatic do_reset(input bit wv, input logic [2*WIDTH-1:0] w);
    rst              = 1'b1;
    bus.word_valid_i = wv;
    bus.word_i       = w;
    bus.ready_i      = 1'b0;
    @(posedge clk);
    #1;
    rst              = 1'b0;
    bus.word_valid_i = 1'b0;
    bus.word_i       = '0;
    mq.delete();
    m_drop = 0;
    m_ovf  = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(bus.valid_o), 64'd0);
    check("rst_fill", 64'(bus.fill_o), 64'd0);
    check("rst_overflow", 64'(bus.overflow_o), 64'd0);
    check("rst_drop", 64'(bus.drop_count_o), 64'd0);
    check("rst_i", {48'd0, bus.i_o}, 64'd0);
    check("rst_q", {48'd0, bus.q_o}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int saved_drop;
    rst              = 1'b1;
    bus.word_valid_i = 1'b0;
    bus.word_i       = '0;
    bus.ready_i      = 1'b0;
    do_reset(1'b0, '0);

    // Single word: visible one cycle after the strobe, then popped.
    step(1'b1, 32'h8001_7FFF, 1'b0);
    check("t1_valid", 64'(bus.valid_o), 64'd1);
    check("t1_i", {48'd0, bus.i_o}, 64'h8001);
    check("t1_i_signed", 64'(int'(bus.i_o)), 64'(-32767));
    check("t1_q", {48'd0, bus.q_o}, 64'h7FFF);
    check("t1_fill", 64'(bus.fill_o), 64'd1);
    step(1'b0, '0, 1'b1);
    check("t1_empty_valid", 64'(bus.valid_o), 64'd0);
    check("t1_empty_fill", 64'(bus.fill_o), 64'd0);

    // Fill past capacity, then drain in order.
    for (int k = 1; k <= 6; k++) step(1'b1, {16'(k), 16'(k)}, 1'b0);
    check("t2_fill", 64'(bus.fill_o), 64'd4);
    check("t2_overflow", 64'(bus.overflow_o), 64'd1);
    check("t2_drop", 64'(bus.drop_count_o), 64'd2);
    for (int k = 0; k < 5; k++) step(1'b0, '0, 1'b1);
    check("t2_drained", 64'(bus.valid_o), 64'd0);

    // Full FIFO with simultaneous push and pop: no drop, new word goes last.
    for (int k = 0; k < 4; k++) step(1'b1, {16'h0A00 + 16'(k), 16'h0B00 + 16'(k)}, 1'b0);
    saved_drop = m_drop;
    step(1'b1, 32'hCAFE_BEEF, 1'b1);
    check("t3_fill", 64'(bus.fill_o), 64'd4);
    check("t3_drop", 64'(bus.drop_count_o), 64'(saved_drop));
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1);
    check("t3_last_i", {48'd0, bus.i_o}, 64'hCAFE);
    check("t3_last_q", {48'd0, bus.q_o}, 64'hBEEF);
    step(1'b0, '0, 1'b1);

    // Sustained stream with pointer wrap, then drain the last one.
    for (int k = 0; k < 10; k++) step(1'b1, $urandom, 1'b1);
    step(1'b0, '0, 1'b1);
    check("t4_empty", 64'(bus.valid_o), 64'd0);

    // Long stall: drop counter saturates and holds.
    for (int k = 0; k < 300; k++) step(1'b1, $urandom, 1'b0);
    check("t4_sat", 64'(bus.drop_count_o), 64'd255);
    step(1'b1, $urandom, 1'b0);
    check("t4_sat_hold", 64'(bus.drop_count_o), 64'd255);

    // Random traffic from a clean state.
    do_reset(1'b0, '0);
    for (int k = 0; k < 1500; k++)
      step($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 50);

    // Reset mid-operation with fill 3, overflow set and a concurrent strobe.
    for (int k = 0; k < 8; k++) step(1'b0, '0, 1'b1);
    for (int k = 0; k < 7; k++) step(1'b1, $urandom, 1'b0);
    step(1'b0, '0, 1'b1);
    check("t5_fill", 64'(bus.fill_o), 64'd3);
    check("t5_overflow", 64'(bus.overflow_o), 64'd1);
    do_reset(1'b1, 32'h1234_5678);
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/iq_sample_unpack.md
# iq_sample_unpack

Downstream consumer of the 32-bit serial-to-parallel merge stage in the FM demodulator front end. It captures each merged word on its one-cycle completion strobe and splits it into a signed in-phase (I) and quadrature (Q) sample pair. It buffers the pairs in a small FIFO and presents them to the demodulator core over a valid/ready handshake, absorbing short stalls of the core. Overflow is detected, counted and flagged rather than silently corrupting the stream.

## Interface

Parameters:
- WIDTH, 16, bit width of one sample; the input word is 2*WIDTH bits.
- DEPTH, 4, FIFO depth in I/Q pairs; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- word_i  input  2*WIDTH  merged word; MSB-first stream, so word_i[2*WIDTH-1:WIDTH] is I and word_i[WIDTH-1:0] is Q.
- word_valid_i  input  1  one-cycle strobe; word_i is valid in this cycle only.
- i_o  output  WIDTH signed  I sample at the FIFO head.
- q_o  output  WIDTH signed  Q sample at the FIFO head.
- valid_o  output  1  head entry is valid.
- ready_i  input  1  consumer accepts the head this cycle.
- fill_o  output  $clog2(DEPTH)+1  number of stored pairs, 0..DEPTH.
- overflow_o  output  1  sticky flag: at least one word was dropped since reset.
- drop_count_o  output  8  count of dropped words, saturating at 255.

## Operation

- Storage: DEPTH entries of {I, Q}, 2*WIDTH bits each.
- Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Occupancy counter fill is 0..DEPTH. Empty is fill==0; full is fill==DEPTH.
- Push: push = word_valid_i && (!full || pop). The entry is written at the write pointer, which then increments.
- Pop: pop = valid_o && ready_i. The read pointer increments.
- fill update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
- Drop: drop = word_valid_i && full && !pop. The word is discarded and no FIFO state changes.
  - overflow_o is set to 1 and stays set until rst.
  - drop_count_o increments by 1 and holds at 255.
- Outputs:
  - valid_o = (fill != 0).
  - i_o and q_o are the head entry, driven combinationally from storage at the read pointer.
  - When valid_o=0, i_o and q_o still show whatever that storage location holds. Consumers must not use them.
- The sample split is a pure bit slice: no sign extension, rounding or swap. Samples are two's complement as received.
- Both ready_i without valid_o and word_valid_i with X data (when valid is 0) must not change state.

## Timing

- Reset: pointers=0, fill_o=0, valid_o=0, overflow_o=0, drop_count_o=0. Storage contents are cleared to 0, so i_o=q_o=0 after reset.
- rst asserted mid-stream, including while word_valid_i=1: the reset wins. The word is not stored and not counted.
- Latency: a word strobed in cycle N appears at the head with valid_o=1 in cycle N+1 if the FIFO was empty. There is no same-cycle bypass.
- Handshake: the head advances in the cycle after pop. i_o, q_o and valid_o hold stable while valid_o=1 and ready_i=0.
- Simultaneous push and pop:
  - When full: both the push and the pop happen, fill stays at DEPTH, and there is no drop.
  - When fill==1: the popped entry leaves and the new entry becomes the head in the next cycle, so valid_o stays 1.
  - When empty: pop cannot occur, so only the push happens.
- Sustained input: a word every cycle with ready_i=1 is passed with no loss at one pair per cycle.
- The upstream strobe rate is at most one per 32 cycles, so DEPTH=4 absorbs a consumer stall of about 128 cycles.

## Test plan

- Reset then a single word: word_i=32'h8001_7FFF strobed at cycle 2, ready_i=0. Required: valid_o=1 at cycle 3, i_o=16'sh8001 (-32767), q_o=16'sh7FFF, fill_o=1. Then ready_i=1 for one cycle: valid_o=0 and fill_o=0 next cycle.
- Fill and overflow: ready_i=0, push 6 words 32'h0001_0001 .. 32'h0006_0006. Required: fill_o=4, overflow_o=1, drop_count_o=2. Draining then yields heads 0001..0004 in order, followed by valid_o=0.
- Full plus simultaneous push and pop: FIFO full, ready_i=1 and word_valid_i=1 in the same cycle. Required: fill_o stays 4, drop_count_o is unchanged, and the new word is read last after the 3 remaining entries.
- Wrap-around and saturation:
  - Stream 10 words with ready_i=1 and a strobe every cycle. All 10 come out in order with i_o/q_o matching, and pointers wrap twice without loss.
  - Then with ready_i=0, strobe 300 words. drop_count_o saturates at 255 and holds there.
- Reset mid-operation: with fill_o=3 and overflow_o=1, assert rst for 1 cycle together with word_valid_i=1. Required: all outputs are at their reset values the next cycle and the strobed word is absent.
